// File: rtl/sequential_multiplier_if.sv
// Start/busy/done handshake and operand/result bus for sequential_multiplier.
// The master issues operations; the slave (the multiplier) returns busy, done and product.
interface sequential_multiplier_if #(
    parameter int unsigned MCAND_W = 16,
    parameter int unsigned MULT_W  = 8
);
    logic               start;
    logic [MCAND_W-1:0] multiplicand;
    logic [MULT_W-1:0]  multiplier;
    logic               busy;
    logic               done;
    logic [MCAND_W-1:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/sequential_multiplier.sv
// Shift-add scaler: product = (multiplicand * multiplier) >> MULT_W, one multiplier bit per clock.
// Define SEQ_MULT_ROUND_EN to round half-up instead of truncating the scaled result.
module sequential_multiplier #(
    parameter int unsigned MCAND_W = 16,
    parameter int unsigned MULT_W  = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    sequential_multiplier_if.slave  bus
);
    localparam int unsigned ACC_W = MCAND_W + MULT_W;
    localparam int unsigned CNT_W = $clog2(MULT_W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   mcand_r;
    logic [MULT_W-1:0]  mult_r;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               busy_r;
    logic               done_r;
    logic [MCAND_W-1:0] product_r;

    logic [ACC_W-1:0]   acc_next;
    logic [MCAND_W-1:0] result;

    // Partial sum including the current multiplier bit, so the last step lands in product directly
    always_comb begin
        acc_next = acc;
        if (mult_r[0]) begin
            acc_next = acc + mcand_r;
        end
    end

`ifdef SEQ_MULT_ROUND_EN
    localparam logic [ACC_W-1:0] HALF_LSB = ACC_W'(1) << (MULT_W - 1);
    logic [ACC_W-1:0] acc_rounded;

    // Largest full product plus half an LSB still fits in ACC_W bits
    always_comb begin
        acc_rounded = acc_next + HALF_LSB;
        result      = MCAND_W'(acc_rounded >> MULT_W);
    end
`else
    always_comb begin
        result = MCAND_W'(acc_next >> MULT_W);
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            mcand_r   <= '0;
            mult_r    <= '0;
            acc       <= '0;
            cnt       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        mcand_r <= ACC_W'(bus.multiplicand);
                        mult_r  <= bus.multiplier;
                        acc     <= '0;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        state   <= BUSY;
                    end else begin
                        state   <= IDLE;
                    end
                end
                BUSY: begin
                    acc     <= acc_next;
                    mcand_r <= mcand_r << 1;
                    mult_r  <= mult_r >> 1;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        product_r <= result;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_sequential_multiplier.sv
// Scoreboard bench for sequential_multiplier: directed vectors push expected products,
// a negedge monitor pops and compares them whenever done pulses.
module tb_sequential_multiplier;
    localparam int unsigned MCAND_W = 16;
    localparam int unsigned MULT_W  = 8;

`ifdef SEQ_MULT_ROUND_EN
    localparam logic [15:0] EXP_1000X1  = 16'd4;
    localparam logic [15:0] EXP_B2B_2ND = 16'd11364;
`else
    localparam logic [15:0] EXP_1000X1  = 16'd3;
    localparam logic [15:0] EXP_B2B_2ND = 16'd11363;
`endif

    logic tb_clk;
    logic nrst;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    logic [15:0] exp_q[$];

    sequential_multiplier_if #(.MCAND_W(MCAND_W), .MULT_W(MULT_W)) bus ();

    sequential_multiplier #(.MCAND_W(MCAND_W), .MULT_W(MULT_W)) dut (
        .clk  (tb_clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    initial cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare product against the scoreboard on every done pulse
    always @(negedge tb_clk) begin
        if (nrst) begin
            if (bus.busy && bus.done) begin
                check("busy_and_done", 1, 0);
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("product", int'(bus.product), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // Wait (bounded) for done; counts busy cycles seen on the way.
    // hold keeps start high, scramble rewrites operands while BUSY.
    task automatic wait_done(input bit hold, input bit scramble, output int busy_cnt, output bit ok);
        busy_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge tb_clk);
            if (!hold) bus.start = 1'b0;
            if (scramble) begin
                bus.multiplicand = 16'($urandom);
                bus.multiplier   = 8'($urandom);
            end
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [15:0] mc, input logic [7:0] mp, input logic [15:0] req,
                          input bit scramble);
        int  bc;
        bit  ok;
        @(negedge tb_clk);
        bus.start        = 1'b1;
        bus.multiplicand = mc;
        bus.multiplier   = mp;
        exp_q.push_back(req);
        wait_done(1'b0, scramble, bc, ok);
        if (ok) begin
            check("busy_cycles", bc, 8);
            @(negedge tb_clk);
            check("done_one_cycle", int'(bus.done), 0);
            check("product_hold", int'(bus.product), int'(req));
        end
    endtask

    initial begin
        int bc;
        bit ok;
        int t1;
        n_cmp = 0;
        n_bad = 0;

        // Reset with start asserted and random operands
        nrst             = 1'b0;
        bus.start        = 1'b1;
        bus.multiplicand = 16'($urandom);
        bus.multiplier   = 8'($urandom);
        repeat (3) @(posedge tb_clk);
        #1;
        check("rst_product", int'(bus.product), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge tb_clk);
        bus.start = 1'b0;
        nrst      = 1'b1;
        repeat (3) @(negedge tb_clk);
        check("idle_product", int'(bus.product), 0);
        check("idle_busy", int'(bus.busy), 0);

        run_op(16'd22727, 8'd247, 16'd21928, 1'b0);
        run_op(16'd65535, 8'd255, 16'd65279, 1'b0);
        run_op(16'd65535, 8'd0,   16'd0,     1'b0);
        run_op(16'd1000,  8'd1,   EXP_1000X1, 1'b0);
        run_op(16'd22727, 8'd247, 16'd21928, 1'b1);

        // Back-to-back: start held through DONE, second multiplier 128
        @(negedge tb_clk);
        bus.start        = 1'b1;
        bus.multiplicand = 16'd22727;
        bus.multiplier   = 8'd247;
        exp_q.push_back(16'd21928);
        @(negedge tb_clk);
        bus.multiplier = 8'd128;
        if (bus.busy) bc = 1; else bc = 0;
        check("b2b_first_busy", bc, 1);
        wait_done(1'b1, 1'b0, bc, ok);
        t1 = cyc;
        exp_q.push_back(EXP_B2B_2ND);
        wait_done(1'b0, 1'b0, bc, ok);
        if (ok) begin
            check("b2b_busy_cycles", bc, 8);
            check("b2b_spacing", cyc - t1, 9);
        end
        @(negedge tb_clk);

        // Reset in the middle of an operation: no done, product cleared
        bus.start        = 1'b1;
        bus.multiplicand = 16'd40000;
        bus.multiplier   = 8'd200;
        repeat (4) begin
            @(negedge tb_clk);
            bus.start = 1'b0;
        end
        check("abort_busy_before", int'(bus.busy), 1);
        nrst = 1'b0;
        #1;
        check("abort_product", int'(bus.product), 0);
        check("abort_busy", int'(bus.busy), 0);
        @(negedge tb_clk);
        nrst = 1'b1;
        repeat (12) @(negedge tb_clk);
        check("abort_no_done_product", int'(bus.product), 0);

        run_op(16'd22727, 8'd247, 16'd21928, 1'b0);

        repeat (3) @(negedge tb_clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
